// File: rtl/axis_pkt_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pkt_fifo_pkg
//  Description : Shared types for the store-and-forward packet FIFO.
//                wr_state_t tracks whether the write side sits between
//                packets (WR_IDLE) or inside one (WR_PKT).
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_pkt_fifo_pkg;

   typedef enum logic [0:0] {
      WR_IDLE = 1'b0,
      WR_PKT  = 1'b1
   } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/axis_pkt_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pkt_fifo_if
//  Description : Packet stream bundle. Used for both sides of the FIFO:
//                the input side is a slave, the output side a master.
//  Signals     : data   - beat (payload + keep packed)
//                last   - last beat of packet
//                header - header word, meaningful with last (input side)
//                drop   - discard packet, meaningful with last (input side)
//                valid  - beat valid
//                ready  - sink accepts
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_pkt_fifo_if #(
   parameter int DATA_WIDTH = 36
) ();
   logic [DATA_WIDTH-1:0] data;
   logic                  last;
   logic [DATA_WIDTH-1:0] header;
   logic                  drop;
   logic                  valid;
   logic                  ready;

   modport master (output data, last, header, drop, valid, input ready);
   modport slave  (input data, last, header, drop, valid, output ready);
endinterface
`default_nettype wire

// File: rtl/axis_pkt_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pkt_fifo_ram
//  Description : DEPTH x WIDTH storage, synchronous write, synchronous read.
//                Port A carries payload beats. Port B lets a packet's header
//                land in its reserved slot in the same cycle as the packet's
//                last payload beat, so back-to-back packets keep full rate.
//                The two ports never target the same slot in one cycle.
//  Ports       : clk, rst (async, active-low, clears read register only)
//                wa_en/wa_addr/wa_data - payload write
//                wb_en/wb_addr/wb_data - header write
//                rd_en/rd_addr/rd_data - registered read
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_fifo_ram #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wa_en,
   input  logic [AW-1:0]    wa_addr,
   input  logic [WIDTH-1:0] wa_data,
   input  logic             wb_en,
   input  logic [AW-1:0]    wb_addr,
   input  logic [WIDTH-1:0] wb_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wa_en) r_mem[wa_addr] <= wa_data;
      if (wb_en) r_mem[wb_addr] <= wb_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       rd_data <= '0;
      else if (rd_en) rd_data <= r_mem[rd_addr];
   end
endmodule
`default_nettype wire

// File: rtl/axis_pkt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pkt_fifo
//  Description : Store-and-forward packet FIFO. A packet is visible at the
//                output only once its last beat is accepted; drop on the
//                last beat discards it. Optionally a header word, sampled
//                with the last beat, is emitted ahead of the payload.
//  Ports       : clk - clock (rising edge)
//                rst - asynchronous active-low reset
//                s   - input stream (slave): data/last/header/drop/valid/ready
//                m   - output stream (master): data/last/valid/ready
//                      (header/drop tied low on the output side)
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_fifo
   import axis_pkt_fifo_pkg::*;
#(
   parameter int DATA_WIDTH     = 36,
   parameter int DEPTH          = 16,
   parameter int RDY_BEFORE_VLD = 0,
   parameter int MAX_PKT_BEATS  = 4,
   parameter int INSERT_HEADER  = 0
) (
   input  logic           clk,
   input  logic           rst,
   axis_pkt_fifo_if.slave  s,
   axis_pkt_fifo_if.master m
);
   localparam int c_aw = $clog2(DEPTH);
   localparam int c_pw = c_aw + 1;
   localparam int c_rw = DATA_WIDTH + 1;
   localparam logic [c_pw-1:0] c_depth = c_pw'(DEPTH);
   localparam logic [c_pw-1:0] c_hdr   = c_pw'(INSERT_HEADER);
   localparam logic [c_pw-1:0] c_one   = c_pw'(1);
   // Space demanded before a packet may start: a whole bounded packet plus
   // its header slot, or just one beat (+header) when bounding is off.
   localparam logic [c_pw-1:0] c_start_need =
      c_pw'(((MAX_PKT_BEATS > 0) ? MAX_PKT_BEATS : 1) + INSERT_HEADER);

   wr_state_t       r_state, w_state_nxt;
   logic [c_pw-1:0] r_wr_ptr, r_cmt_ptr, r_rd_ptr;
   logic            r_alive;
   logic [c_pw-1:0] w_wr_addr, w_used, w_free, w_rd_addr;
   logic            w_s_ready, w_s_xfer, w_commit;
   logic            w_rd_en, w_rd_adv;
   logic [c_rw-1:0] w_ram_q;

   // Free space is measured from the read pointer, so an open (uncommitted)
   // packet already counts against it.
   assign w_used   = r_wr_ptr - r_rd_ptr;
   assign w_free   = c_depth - w_used;
   assign w_s_xfer = s.valid & w_s_ready;
   assign w_commit = w_s_xfer & s.last & ~s.drop;
   assign s.ready  = w_s_ready;
   assign m.header = '0;
   assign m.drop   = 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= WR_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_s_ready   = 1'b0;
      w_wr_addr   = r_wr_ptr;
      case (r_state)
         WR_IDLE: begin
            // Between packets wr_ptr equals cmt_ptr; skip the header slot.
            w_wr_addr = r_cmt_ptr + c_hdr;
            w_s_ready = r_alive && (w_free >= c_start_need);
            if (s.valid && w_s_ready && !s.last) w_state_nxt = WR_PKT;
         end
         WR_PKT: begin
            // Space for a bounded packet was reserved at its start, so this
            // can only fall for packets longer than MAX_PKT_BEATS.
            w_s_ready = (w_free != '0);
            if (s.valid && w_s_ready && s.last) w_state_nxt = WR_IDLE;
         end
         default: w_state_nxt = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr  <= '0;
         r_cmt_ptr <= '0;
         r_rd_ptr  <= '0;
         r_alive   <= 1'b0;
      end else begin
         r_alive <= 1'b1;
         if (w_s_xfer) begin
            if (s.last && s.drop) r_wr_ptr <= r_cmt_ptr;
            else                  r_wr_ptr <= w_wr_addr + c_one;
            if (w_commit)         r_cmt_ptr <= w_wr_addr + c_one;
         end
         if (w_rd_adv) r_rd_ptr <= r_rd_ptr + c_one;
      end
   end

   axis_pkt_fifo_ram #(
      .WIDTH (c_rw),
      .DEPTH (DEPTH),
      .AW    (c_aw)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wa_en   (w_s_xfer),
      .wa_addr (w_wr_addr[c_aw-1:0]),
      .wa_data ({s.last, s.data}),
      .wb_en   (w_commit & (INSERT_HEADER != 0)),
      .wb_addr (r_cmt_ptr[c_aw-1:0]),
      .wb_data ({1'b0, s.header}),
      .rd_en   (w_rd_en),
      .rd_addr (w_rd_addr[c_aw-1:0]),
      .rd_data (w_ram_q)
   );

   if (RDY_BEFORE_VLD != 0) begin : g_rbv
      logic [c_pw-1:0] r_cmt_d;
      logic            w_avail;

      // The RAM re-reads the head slot every cycle. A slot written on the
      // commit edge is only read back one edge later, hence the delayed
      // commit pointer.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) r_cmt_d <= '0;
         else      r_cmt_d <= r_cmt_ptr;
      end

      assign w_avail   = (r_rd_ptr != r_cmt_d);
      assign w_rd_adv  = w_avail & m.ready;
      assign w_rd_en   = 1'b1;
      assign w_rd_addr = r_rd_ptr + {{c_aw{1'b0}}, w_rd_adv};
      assign m.valid   = w_rd_adv;
      assign m.data    = w_ram_q[DATA_WIDTH-1:0];
      assign m.last    = w_ram_q[DATA_WIDTH];
   end else begin : g_fwft
      logic            r_rv, r_ov;
      logic [c_rw-1:0] r_oq;
      logic            w_avail, w_out_ld;

      // Two-stage pipe: RAM read register (r_rv) feeding the output
      // register (r_ov). A read is issued whenever the RAM stage is empty
      // or drains this cycle, so one beat per cycle flows when unblocked.
      assign w_avail   = (r_rd_ptr != r_cmt_ptr);
      assign w_out_ld  = r_rv & (~r_ov | m.ready);
      assign w_rd_en   = w_avail & (~r_rv | w_out_ld);
      assign w_rd_adv  = w_rd_en;
      assign w_rd_addr = r_rd_ptr;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_rv <= 1'b0;
            r_ov <= 1'b0;
            r_oq <= '0;
         end else begin
            if (w_rd_en)       r_rv <= 1'b1;
            else if (w_out_ld) r_rv <= 1'b0;
            if (w_out_ld) begin
               r_ov <= 1'b1;
               r_oq <= w_ram_q;
            end else if (m.ready) begin
               r_ov <= 1'b0;
            end
         end
      end

      assign m.valid = r_ov;
      assign m.data  = r_oq[DATA_WIDTH-1:0];
      assign m.last  = r_oq[DATA_WIDTH];
   end
endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_pkt_fifo
//  Description : Directed bench for axis_pkt_fifo (header insertion on,
//                MAX_PKT_BEATS=4, DEPTH=16) with an FWFT instance and a
//                ready-before-valid instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_fifo;
   localparam int DW = 36;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   drv_done = 1'b0;
   logic [DW:0] sb [$];

   always #5 clk = ~clk;

   axis_pkt_fifo_if #(.DATA_WIDTH(DW)) s_if ();
   axis_pkt_fifo_if #(.DATA_WIDTH(DW)) m_if ();
   axis_pkt_fifo_if #(.DATA_WIDTH(DW)) s2_if ();
   axis_pkt_fifo_if #(.DATA_WIDTH(DW)) m2_if ();

   axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(16), .RDY_BEFORE_VLD(0),
                   .MAX_PKT_BEATS(4), .INSERT_HEADER(1))
      dut (.clk(clk), .rst(rst), .s(s_if), .m(m_if));

   axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(16), .RDY_BEFORE_VLD(1),
                   .MAX_PKT_BEATS(4), .INSERT_HEADER(1))
      dut2 (.clk(clk), .rst(rst), .s(s2_if), .m(m2_if));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the beat transferred.
   task automatic send_beat(input logic [DW-1:0] d, input logic l,
                            input logic [DW-1:0] h, input logic dr);
      int n = 0;
      s_if.valid = 1'b1; s_if.data = d; s_if.last = l;
      s_if.header = h;   s_if.drop = dr;
      while (s_if.ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("s_ready_wait", s_if.ready, 1'b1);
      @(negedge clk);
      s_if.valid = 1'b0;
   endtask

   task automatic send_pkt(input int len, input logic [DW-1:0] base,
                           input logic [DW-1:0] h, input logic dr);
      for (int i = 0; i < len; i++)
         send_beat(base + DW'(i), (i == len - 1), h, dr);
   endtask

   task automatic recv_beat(input string tag, input logic [DW-1:0] d, input logic l);
      int n = 0;
      m_if.ready = 1'b1;
      while (m_if.valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, m_if.valid, 1'b1);
      chk({tag, "_data"}, m_if.data, d);
      chk({tag, "_last"}, m_if.last, l);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      s_if.valid = 0; s_if.data = '0; s_if.last = 0; s_if.header = '0; s_if.drop = 0;
      s2_if.valid = 0; s2_if.data = '0; s2_if.last = 0; s2_if.header = '0; s2_if.drop = 0;
      m_if.ready = 0; m2_if.ready = 0;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      chk("rst_s_ready", s_if.ready, 1'b0);
      chk("rst_m_valid", m_if.valid, 1'b0);
      chk("rst_m_last", m_if.last, 1'b0);
      chk("rst_m_data", m_if.data, '0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_s_ready", s_if.ready, 1'b1);

      // ---- 3-beat packet with header, latency and ordering ----
      send_pkt(3, 36'h1_1111_0000, 36'hA_BCDE_0001, 1'b0);
      chk("lat0_m_valid", m_if.valid, 1'b0);
      @(negedge clk);
      chk("lat1_m_valid", m_if.valid, 1'b0);
      @(negedge clk);
      chk("lat2_m_valid", m_if.valid, 1'b1);
      recv_beat("p1_hdr", 36'hA_BCDE_0001, 1'b0);
      recv_beat("p1_d0", 36'h1_1111_0000, 1'b0);
      recv_beat("p1_d1", 36'h1_1111_0001, 1'b0);
      recv_beat("p1_d2", 36'h1_1111_0002, 1'b1);
      m_if.ready = 1'b0;
      chk("p1_empty", m_if.valid, 1'b0);

      // ---- dropped packet, then a normal one ----
      send_pkt(3, 36'h2_2222_0000, 36'hD_EAD0_0000, 1'b1);
      repeat (4) @(negedge clk);
      chk("drop_no_out", m_if.valid, 1'b0);
      send_pkt(2, 36'h3_3333_0000, 36'hB_0000_0002, 1'b0);
      recv_beat("p2_hdr", 36'hB_0000_0002, 1'b0);
      recv_beat("p2_d0", 36'h3_3333_0000, 1'b0);
      recv_beat("p2_d1", 36'h3_3333_0001, 1'b1);
      m_if.ready = 1'b0;

      // ---- fill: three 4-beat packets with output stalled ----
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 4; i++) begin
            chk("fill_s_ready", s_if.ready, 1'b1);
            send_beat(36'h4_0000_0000 + DW'(p * 16 + i), (i == 3),
                      36'h8_0000_00F0 + DW'(p), 1'b0);
         end
      end
      s_if.valid = 1'b1; s_if.data = 36'h4_0000_0FFF; s_if.last = 1'b0; s_if.drop = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("fill_4th_s_ready", s_if.ready, 1'b0);
         @(negedge clk);
      end
      s_if.valid = 1'b0;
      for (int p = 0; p < 3; p++) begin
         recv_beat("fill_hdr", 36'h8_0000_00F0 + DW'(p), 1'b0);
         for (int i = 0; i < 4; i++)
            recv_beat("fill_d", 36'h4_0000_0000 + DW'(p * 16 + i), (i == 3));
      end
      m_if.ready = 1'b0;
      chk("drained_s_ready", s_if.ready, 1'b1);

      // ---- random packets, random drop and backpressure, scoreboard ----
      fork
         begin
            logic [DW-1:0] pd [4];
            logic [DW-1:0] hd;
            int len;
            logic dr;
            for (int p = 0; p < 1000; p++) begin
               len = $urandom_range(4, 1);
               dr  = ($urandom_range(3, 0) == 0);
               hd  = DW'({$urandom(), $urandom()});
               for (int i = 0; i < len; i++) begin
                  pd[i] = DW'({$urandom(), $urandom()});
                  if ($urandom_range(3, 0) == 0) @(negedge clk);
                  send_beat(pd[i], (i == len - 1), hd, dr);
               end
               if (!dr) begin
                  sb.push_back({1'b0, hd});
                  for (int i = 0; i < len; i++) sb.push_back({(i == len - 1), pd[i]});
               end
            end
            drv_done = 1'b1;
         end
         begin
            int cyc = 0;
            logic [DW:0] exp;
            while (!(drv_done && sb.size() == 0) && cyc < 40000) begin
               @(negedge clk);
               m_if.ready = ($urandom_range(9, 0) < 7);
               #1;
               if (m_if.valid && m_if.ready) begin
                  if (sb.size() == 0) begin
                     chk("rand_unexpected", m_if.valid, 1'b0);
                  end else begin
                     exp = sb.pop_front();
                     chk("rand_beat", {m_if.last, m_if.data}, exp);
                  end
               end
               cyc++;
            end
            @(negedge clk);
            m_if.ready = 1'b0;
            chk("rand_drain", sb.size(), 0);
         end
      join
      repeat (3) @(negedge clk);
      chk("rand_empty", m_if.valid, 1'b0);

      // ---- reset mid-packet ----
      send_pkt(2, 36'h5_5555_0000, 36'hC_0000_0005, 1'b0);
      repeat (3) @(negedge clk);
      chk("prerst_m_valid", m_if.valid, 1'b1);
      send_beat(36'h6_6666_0000, 1'b0, 36'hC_0000_0006, 1'b0);
      send_beat(36'h6_6666_0001, 1'b0, 36'hC_0000_0006, 1'b0);
      rst = 1'b0;
      #1;
      chk("midrst_m_valid", m_if.valid, 1'b0);
      chk("midrst_s_ready", s_if.ready, 1'b0);
      chk("midrst_m_data", m_if.data, '0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      m_if.ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("postrst_empty", m_if.valid, 1'b0);
      send_pkt(1, 36'h7_7777_0000, 36'hC_0000_0007, 1'b0);
      recv_beat("postrst_hdr", 36'hC_0000_0007, 1'b0);
      recv_beat("postrst_d0", 36'h7_7777_0000, 1'b1);
      m_if.ready = 1'b0;

      // ---- ready-before-valid instance ----
      for (int i = 0; i < 2; i++) begin
         s2_if.valid = 1'b1; s2_if.data = 36'h9_9999_0000 + DW'(i);
         s2_if.last = (i == 1); s2_if.header = 36'hE_0000_0009; s2_if.drop = 1'b0;
         chk("rbv_s_ready", s2_if.ready, 1'b1);
         @(negedge clk);
      end
      s2_if.valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rbv_hold_m_valid", m2_if.valid, 1'b0);
      end
      m2_if.ready = 1'b1;
      #1;
      chk("rbv_b0_valid", m2_if.valid, 1'b1);
      chk("rbv_b0_data", m2_if.data, 36'hE_0000_0009);
      chk("rbv_b0_last", m2_if.last, 1'b0);
      @(negedge clk); #1;
      chk("rbv_b1_valid", m2_if.valid, 1'b1);
      chk("rbv_b1_data", m2_if.data, 36'h9_9999_0000);
      chk("rbv_b1_last", m2_if.last, 1'b0);
      @(negedge clk); #1;
      chk("rbv_b2_valid", m2_if.valid, 1'b1);
      chk("rbv_b2_data", m2_if.data, 36'h9_9999_0001);
      chk("rbv_b2_last", m2_if.last, 1'b1);
      @(negedge clk); #1;
      chk("rbv_empty", m2_if.valid, 1'b0);
      m2_if.ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
